lsf_lut_rd_seq: RTL and testbench

- Sequences LUT reads for the Legendre segment finder.
- Takes one start address per candidate (the registered output of the ROM address stage) and issues BURST_LEN consecutive reads across the banked LUT ROMs.
- Realigns the returned words with beat index, last flag and the candidate angle, and streams them to the Legendre transform.
- Owns the ROM read ports: it is the only block driving rom_rd_en.

---
 rtl/lsf_lut_rd_seq.sv | 175 +++++++++++++++++
 tb/tb_lsf_lut_rd_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsf_lut_rd_seq.sv
// LUT read sequencer: turns one start address into BURST_LEN banked ROM reads and streams the tagged words out.
// Define LSF_LUT_RD_SEQ_OVERLAP_EN to let the next burst start straight after the current one with no gap.
module lsf_lut_rd_seq #(
  parameter int LUT_ADDR_WIDTH  = 12,
  parameter int ROM_INDEX_WIDTH = 3,
  parameter int BURST_LEN       = 8,
  parameter int ROM_LATENCY     = 2,
  parameter int DATA_WIDTH      = 18,
  parameter int ANGLE_WIDTH     = 15
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      flush,
  input  logic                                      req_vld,
  output logic                                      req_rdy,
  input  logic [LUT_ADDR_WIDTH-1:0]                 req_start_addr,
  input  logic [ANGLE_WIDTH-1:0]                    req_angle,
  output logic                                      rom_rd_en,
  output logic [ROM_INDEX_WIDTH-1:0]                rom_sel,
  output logic [LUT_ADDR_WIDTH-ROM_INDEX_WIDTH-1:0] rom_rd_addr,
  input  logic [DATA_WIDTH-1:0]                     rom_rd_data,
  output logic                                      out_vld,
  output logic [DATA_WIDTH-1:0]                     out_data,
  output logic [$clog2(BURST_LEN)-1:0]              out_idx,
  output logic                                      out_last,
  output logic [ANGLE_WIDTH-1:0]                    out_angle,
  output logic                                      busy
);

  localparam int IDX_W = $clog2(BURST_LEN);
  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(BURST_LEN - 1);

`ifdef LSF_LUT_RD_SEQ_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic                   vld;
    logic [IDX_W-1:0]       idx;
    logic                   last;
    logic [ANGLE_WIDTH-1:0] angle;
  } tag_t;

  state_t                    r_state;
  logic [IDX_W-1:0]          r_k;
  logic [LUT_ADDR_WIDTH-1:0] r_addr;
  logic [ANGLE_WIDTH-1:0]    r_angle;
  logic                      r_rd_en;
  logic                      r_req_rdy;

  tag_t                      r_tag [1:ROM_LATENCY];
  tag_t                      w_tag0;
  logic                      w_pipe_busy;
  logic                      w_accept;

  logic                      r_out_vld;
  logic [DATA_WIDTH-1:0]     r_out_data;
  logic [IDX_W-1:0]          r_out_idx;
  logic                      r_out_last;
  logic [ANGLE_WIDTH-1:0]    r_out_angle;

  // req_rdy is only raised in states where starting a burst is legal, so an accept always starts one.
  assign w_accept = req_vld & r_req_rdy & ~flush;

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_addr    <= '0;
      r_angle   <= '0;
      r_rd_en   <= 1'b0;
      r_req_rdy <= 1'b1;
    end else if (flush) begin
      r_state   <= S_IDLE;
      r_rd_en   <= 1'b0;
      r_req_rdy <= 1'b1;
    end else if (w_accept) begin
      r_state   <= S_ISSUE;
      r_k       <= '0;
      r_addr    <= req_start_addr;
      r_angle   <= req_angle;
      r_rd_en   <= 1'b1;
      r_req_rdy <= 1'b0;
    end else begin
      case (r_state)
        S_ISSUE: begin
          if (r_k != LAST_K) begin
            r_k       <= r_k + IDX_W'(1);
            r_addr    <= r_addr + LUT_ADDR_WIDTH'(1);
            r_rd_en   <= 1'b1;
            r_req_rdy <= OVERLAP && (r_k == LAST_K - IDX_W'(1));
          end else begin
            r_state   <= S_DRAIN;
            r_rd_en   <= 1'b0;
            r_req_rdy <= OVERLAP;
          end
        end
        S_DRAIN: begin
          if (!w_pipe_busy) begin
            r_state   <= S_IDLE;
            r_req_rdy <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_rd_en   <= 1'b0;
          r_req_rdy <= 1'b1;
        end
      endcase
    end
  end

  // Tag of the strobe currently on the ROM port; it travels with the read until the data returns.
  assign w_tag0 = '{vld: r_rd_en, idx: r_k, last: (r_k == LAST_K), angle: r_angle};

  always_comb begin
    w_pipe_busy = 1'b0;
    for (int i = 1; i <= ROM_LATENCY; i++) begin
      w_pipe_busy = w_pipe_busy | r_tag[i].vld;
    end
  end

  // NOTE: the tag pipe is a handful of flops, not a RAM, so it is reset like any other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= ROM_LATENCY; i++) begin
        r_tag[i] <= '0;
      end
      r_out_vld   <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      r_out_angle <= '0;
    end else if (flush) begin
      for (int i = 1; i <= ROM_LATENCY; i++) begin
        r_tag[i] <= '0;
      end
      r_out_vld <= 1'b0;
    end else begin
      r_tag[1] <= w_tag0;
      for (int i = ROM_LATENCY; i >= 2; i--) begin
        r_tag[i] <= r_tag[i-1];
      end
      r_out_vld <= r_tag[ROM_LATENCY].vld;
      // Payload only moves on a valid beat so it holds between bursts.
      if (r_tag[ROM_LATENCY].vld) begin
        r_out_data  <= rom_rd_data;
        r_out_idx   <= r_tag[ROM_LATENCY].idx;
        r_out_last  <= r_tag[ROM_LATENCY].last;
        r_out_angle <= r_tag[ROM_LATENCY].angle;
      end
    end
  end

  assign req_rdy     = r_req_rdy;
  assign rom_rd_en   = r_rd_en;
  assign rom_sel     = r_addr[ROM_INDEX_WIDTH-1:0];
  assign rom_rd_addr = r_addr[LUT_ADDR_WIDTH-1:ROM_INDEX_WIDTH];
  assign out_vld     = r_out_vld;
  assign out_data    = r_out_data;
  assign out_idx     = r_out_idx;
  assign out_last    = r_out_last;
  assign out_angle   = r_out_angle;
  assign busy        = (r_state != S_IDLE) | w_pipe_busy;

endmodule

// File: tb/tb_lsf_lut_rd_seq.sv
// Self-checking bench for lsf_lut_rd_seq: banked ROM model, strobe/beat scoreboards and directed corner cases.
module tb_lsf_lut_rd_seq;

  localparam int LAW = 12;
  localparam int RIW = 3;
  localparam int BL  = 8;
  localparam int RL  = 2;
  localparam int DW  = 18;
  localparam int AW  = 15;
`ifdef LSF_LUT_RD_SEQ_OVERLAP_EN
  localparam int B2B_GAP = BL;
`else
  localparam int B2B_GAP = BL + RL + 2;
`endif

  logic               clk;
  logic               rst_n;
  logic               flush;
  logic               req_vld;
  logic               req_rdy;
  logic [LAW-1:0]     req_start_addr;
  logic [AW-1:0]      req_angle;
  logic               rom_rd_en;
  logic [RIW-1:0]     rom_sel;
  logic [LAW-RIW-1:0] rom_rd_addr;
  logic [DW-1:0]      rom_rd_data;
  logic               out_vld;
  logic [DW-1:0]      out_data;
  logic [2:0]         out_idx;
  logic               out_last;
  logic [AW-1:0]      out_angle;
  logic               busy;

  lsf_lut_rd_seq #(
    .LUT_ADDR_WIDTH(LAW), .ROM_INDEX_WIDTH(RIW), .BURST_LEN(BL),
    .ROM_LATENCY(RL), .DATA_WIDTH(DW), .ANGLE_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .req_start_addr(req_start_addr), .req_angle(req_angle),
    .rom_rd_en(rom_rd_en), .rom_sel(rom_sel), .rom_rd_addr(rom_rd_addr),
    .rom_rd_data(rom_rd_data),
    .out_vld(out_vld), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .out_angle(out_angle), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Distinct word per LUT address so misrouted or stale reads show up in out_data.
  function automatic logic [DW-1:0] rom_word(input logic [LAW-1:0] a);
    logic [5:0] lo;
    lo = a[5:0] + 6'd13;
    return {a ^ 12'hA5C, lo};
  endfunction

  // ROM model: sampled strobe -> data valid RL cycles after the strobe cycle; junk when not read.
  logic [DW-1:0] rom_pipe [RL];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_rd_en ? rom_word({rom_rd_addr, rom_sel}) : 18'h2BAD5;
    for (int i = 1; i < RL; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_rd_data = rom_pipe[RL-1];

  typedef struct {
    int             cyc;
    int             k;
    logic [RIW-1:0] sel;
    logic [LAW-RIW-1:0] addr;
  } stb_t;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
    logic [2:0]    idx;
    logic          last;
    logic [AW-1:0] angle;
  } beat_t;

  stb_t  sq[$];
  beat_t bq[$];
  logic [RIW-1:0]     obs_sel  [BL];
  logic [LAW-RIW-1:0] obs_addr [BL];

  stb_t  ms;
  beat_t mb;
  bit    me;
  bit    be;

  // Monitor: every cycle the strobe and beat outputs must match exactly what the scoreboards predict.
  always @(negedge clk) begin
    me = (sq.size() > 0) && (sq[0].cyc == cyc);
    check("rom_rd_en", rom_rd_en, me);
    if (me) begin
      ms = sq.pop_front();
      if (rom_rd_en) begin
        check("rom_sel", rom_sel, ms.sel);
        check("rom_rd_addr", rom_rd_addr, ms.addr);
        obs_sel[ms.k]  = rom_sel;
        obs_addr[ms.k] = rom_rd_addr;
      end
    end
    be = (bq.size() > 0) && (bq[0].cyc == cyc);
    check("out_vld", out_vld, be);
    if (be) begin
      mb = bq.pop_front();
      if (out_vld) begin
        check("out_data", out_data, mb.data);
        check("out_idx", out_idx, mb.idx);
        check("out_last", out_last, mb.last);
        check("out_angle", out_angle, mb.angle);
      end
    end
  end

  task automatic do_req(input logic [LAW-1:0] s, input logic [AW-1:0] a, input bit keep, output int acc);
    logic [LAW-1:0] ad;
    acc = -1;
    req_start_addr = s;
    req_angle      = a;
    req_vld        = 1'b1;
    for (int t = 0; t < 64 && acc < 0; t++) begin
      @(negedge clk);
      if (req_rdy && !flush) begin
        acc = cyc;
        for (int i = 0; i < BL; i++) begin
          ad = s + 12'(i);
          sq.push_back('{cyc: acc + 1 + i, k: i, sel: ad[RIW-1:0], addr: ad[LAW-1:RIW]});
          bq.push_back('{cyc: acc + RL + 2 + i, data: rom_word(ad), idx: 3'(i),
                         last: (i == BL - 1), angle: a});
        end
      end
      @(posedge clk); #1;
    end
    check("req_accept_timeout", acc >= 0, 1);
    if (!keep) req_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sq.size() != 0 || bq.size() != 0) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_timeout", t < 100, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [LAW-1:0]     start;
    logic [AW-1:0]      angle;
    int                 k;
    logic [RIW-1:0]     sel;
    logic [LAW-RIW-1:0] addr;
  } vec_t;

  vec_t vecs [6];
  int   acc0;
  int   acc1;

  initial begin
    vecs[0] = '{start: 12'h0FA, angle: 15'h1234, k: 0, sel: 3'd2, addr: 9'h01F};
    vecs[1] = '{start: 12'h0FA, angle: 15'h1234, k: 6, sel: 3'd0, addr: 9'h020};
    vecs[2] = '{start: 12'hFFE, angle: 15'h0777, k: 2, sel: 3'd0, addr: 9'h000};
    vecs[3] = '{start: 12'hFFE, angle: 15'h0777, k: 1, sel: 3'd7, addr: 9'h1FF};
    vecs[4] = '{start: 12'h555, angle: 15'h7FFF, k: 7, sel: 3'd4, addr: 9'h0AB};
    vecs[5] = '{start: 12'h000, angle: 15'h0001, k: 3, sel: 3'd3, addr: 9'h000};

    rst_n = 1'b0; flush = 1'b0; req_vld = 1'b0;
    req_start_addr = '0; req_angle = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_rdy", req_rdy, 1);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single bursts, including address wrap, with spot checks of the issued bank/address.
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < BL; k++) begin obs_sel[k] = 'x; obs_addr[k] = 'x; end
      do_req(vecs[v].start, vecs[v].angle, 1'b0, acc0);
      wait_drain();
      check("spot_sel", obs_sel[vecs[v].k], vecs[v].sel);
      check("spot_addr", obs_addr[vecs[v].k], vecs[v].addr);
      check("idle_busy", busy, 0);
      check("idle_req_rdy", req_rdy, 1);
      if (v == 0) begin
        check("hold_idx", out_idx, 3'd7);
        check("hold_last", out_last, 1);
        check("hold_angle", out_angle, 15'h1234);
        check("hold_data", out_data, rom_word(12'h101));
      end
    end

    // Request held valid across a burst: next accept is as early as the build allows.
    do_req(12'h200, 15'h0AAA, 1'b1, acc0);
    do_req(12'h7F8, 15'h0555, 1'b0, acc1);
    check("b2b_accept_gap", acc1 - acc0, B2B_GAP);
    wait_drain();

    // Flush in cycle 5 of a burst.
    do_req(12'h321, 15'h0ABC, 1'b0, acc0);
    repeat (4) @(posedge clk);
    #1;
    check("pre_flush_busy", busy, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sq.delete(); bq.delete();
    check("flush_rd_en", rom_rd_en, 0);
    check("flush_out_vld", out_vld, 0);
    check("flush_busy", busy, 0);
    check("flush_req_rdy", req_rdy, 1);
    repeat (10) @(posedge clk);
    #1;
    do_req(12'h0FA, 15'h1234, 1'b0, acc0);
    wait_drain();

    // Asynchronous reset in cycle 6 of a burst.
    do_req(12'h444, 15'h3210, 1'b0, acc0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    sq.delete(); bq.delete();
    #1;
    check("arst_rd_en", rom_rd_en, 0);
    check("arst_sel", rom_sel, 0);
    check("arst_rd_addr", rom_rd_addr, 0);
    check("arst_out_vld", out_vld, 0);
    check("arst_out_data", out_data, 0);
    check("arst_out_idx", out_idx, 0);
    check("arst_out_last", out_last, 0);
    check("arst_out_angle", out_angle, 0);
    check("arst_busy", busy, 0);
    check("arst_req_rdy", req_rdy, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_req_rdy", req_rdy, 1);
    do_req(12'hFFE, 15'h0042, 1'b0, acc0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
